// File: rtl/axi4_burst_slave_mem.sv
// AXI4 burst slave (FIXED/INCR/WRAP, 1-256 beats) over a word-addressed register memory.
// Define AXI_SLAVE_ERR_COUNT_EN to add the saturating SLVERR counter output S_AXI_ERR_CNT.
module axi4_burst_slave_mem #(
  parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_MEM_ADDR_BITS    = 6
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
`ifdef AXI_SLAVE_ERR_COUNT_EN
  ,
  output logic [15:0]                     S_AXI_ERR_CNT
`endif
);

  localparam int unsigned ID_W   = C_S_AXI_ID_WIDTH;
  localparam int unsigned ADDR_W = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned DATA_W = C_S_AXI_DATA_WIDTH;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = C_MEM_ADDR_BITS;
  localparam int unsigned DEPTH  = 1 << IDX_W;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Any request we cannot honour exactly is still served beat by beat, but answered SLVERR.
  function automatic logic req_err(input logic [1:0] addr_lo, input logic [7:0] len,
                                   input logic [2:0] size, input logic [1:0] burst);
    logic bad_wrap;
    bad_wrap = (burst == BURST_WRAP) && (!wrap_len_ok(len) || (addr_lo != 2'b00));
    return (size != 3'b010) || (burst == 2'b11) || bad_wrap;
  endfunction

  // Reserved burst type and illegal WRAP lengths fall back to INCR addressing.
  function automatic logic [1:0] eff_burst(input logic [7:0] len, input logic [1:0] burst);
    logic [1:0] b;
    b = burst;
    if (burst == 2'b11) b = BURST_INCR;
    else if (burst == BURST_WRAP && !wrap_len_ok(len)) b = BURST_INCR;
    return b;
  endfunction

  // WRAP mask is (len+1)*4-1, i.e. {len,2'b11} for the legal lengths 1/3/7/15.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [3:0] len_lo,
                                                  input logic [1:0] burst);
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] nxt;
    mask = ADDR_W'({len_lo, 2'b11});
    case (burst)
      BURST_FIXED: nxt = addr;
      BURST_WRAP:  nxt = (addr & ~mask) | ((addr + ADDR_W'(4)) & mask);
      default:     nxt = addr + ADDR_W'(4);
    endcase
    return nxt;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  w_state_t          w_state;
  logic [ID_W-1:0]   w_id;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len;
  logic [1:0]        w_burst;
  logic [8:0]        w_beat;
  logic              w_err;

  r_state_t          r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic [1:0]        r_burst;
  logic [7:0]        r_beat;

  logic              w_in_range_c;
  logic              w_at_last_c;
  logic              w_beat_c;
  logic              w_err_nxt_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] w_addr_nxt_c;
  logic [ADDR_W-1:0] r_addr_nxt_c;

  // Beats beyond len+1 are absorbed without touching memory or the address.
  always_comb begin
    w_in_range_c = (w_beat <= {1'b0, w_len});
    w_at_last_c  = (w_beat == {1'b0, w_len});
    w_beat_c     = S_AXI_WVALID & S_AXI_WREADY;
    mem_we_c     = w_beat_c & w_in_range_c;
    w_err_nxt_c  = w_err | (S_AXI_WLAST ? !w_at_last_c : w_at_last_c);
    w_addr_nxt_c = next_addr(w_addr, w_len[3:0], w_burst);
    r_addr_nxt_c = next_addr(r_addr, r_len[3:0], r_burst);
  end

  // Memory contents survive reset.
  always_ff @(posedge S_AXI_ACLK) begin
    if (mem_we_c) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (S_AXI_WSTRB[b]) mem[w_addr[IDX_W+1:2]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  // Write channel FSM
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state       <= W_IDLE;
      w_id          <= '0;
      w_addr        <= '0;
      w_len         <= '0;
      w_burst       <= BURST_INCR;
      w_beat        <= '0;
      w_err         <= 1'b0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BID     <= '0;
      S_AXI_BRESP   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          S_AXI_AWREADY <= 1'b1;
          if (S_AXI_AWVALID && S_AXI_AWREADY) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b1;
            w_id          <= S_AXI_AWID;
            w_addr        <= S_AXI_AWADDR;
            w_len         <= S_AXI_AWLEN;
            w_burst       <= eff_burst(S_AXI_AWLEN, S_AXI_AWBURST);
            w_beat        <= '0;
            w_err         <= req_err(S_AXI_AWADDR[1:0], S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST);
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat_c) begin
            if (w_in_range_c) begin
              w_addr <= w_addr_nxt_c;
              w_beat <= w_beat + 9'd1;
            end
            w_err <= w_err_nxt_c;
            if (S_AXI_WLAST) begin
              S_AXI_WREADY <= 1'b0;
              S_AXI_BVALID <= 1'b1;
              S_AXI_BID    <= w_id;
              S_AXI_BRESP  <= w_err_nxt_c ? RESP_SLVERR : RESP_OKAY;
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BVALID && S_AXI_BREADY) begin
            S_AXI_BVALID  <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel FSM; RDATA is registered so a same-cycle write is seen on the next beat only.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state       <= R_IDLE;
      r_addr        <= '0;
      r_len         <= '0;
      r_burst       <= BURST_INCR;
      r_beat        <= '0;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RID     <= '0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
      S_AXI_RLAST   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          S_AXI_ARREADY <= 1'b1;
          if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_RID     <= S_AXI_ARID;
            r_addr        <= S_AXI_ARADDR;
            r_len         <= S_AXI_ARLEN;
            r_burst       <= eff_burst(S_AXI_ARLEN, S_AXI_ARBURST);
            r_beat        <= '0;
            S_AXI_RDATA   <= mem[S_AXI_ARADDR[IDX_W+1:2]];
            S_AXI_RRESP   <= req_err(S_AXI_ARADDR[1:0], S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST)
                             ? RESP_SLVERR : RESP_OKAY;
            S_AXI_RLAST   <= (S_AXI_ARLEN == 8'd0);
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (S_AXI_RVALID && S_AXI_RREADY) begin
            if (S_AXI_RLAST) begin
              S_AXI_RVALID  <= 1'b0;
              S_AXI_RLAST   <= 1'b0;
              S_AXI_ARREADY <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_addr      <= r_addr_nxt_c;
              r_beat      <= r_beat + 8'd1;
              S_AXI_RDATA <= mem[r_addr_nxt_c[IDX_W+1:2]];
              S_AXI_RLAST <= ((r_beat + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

`ifdef AXI_SLAVE_ERR_COUNT_EN
  logic [1:0]  err_inc_c;
  logic [16:0] err_sum_c;

  // One count per SLVERR B response and per SLVERR read burst (on its RLAST beat).
  always_comb begin
    err_inc_c = 2'(S_AXI_BVALID & S_AXI_BREADY & (S_AXI_BRESP == RESP_SLVERR))
              + 2'(S_AXI_RVALID & S_AXI_RREADY & S_AXI_RLAST & (S_AXI_RRESP == RESP_SLVERR));
    err_sum_c = 17'(S_AXI_ERR_CNT) + 17'(err_inc_c);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) S_AXI_ERR_CNT <= '0;
    else                S_AXI_ERR_CNT <= err_sum_c[16] ? 16'hFFFF : err_sum_c[15:0];
  end
`endif

endmodule

// File: tb/tb_axi4_burst_slave_mem.sv
// Directed bench for axi4_burst_slave_mem: write/read bursts, read vector table, corner sequences.
`timescale 1ns/1ps
module tb_axi4_burst_slave_mem;

  localparam int unsigned ID_W = 1;

  logic        tb_ACLK = 1'b0;
  logic        tb_ARESETN;
  logic [ID_W-1:0] awid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
`ifdef AXI_SLAVE_ERR_COUNT_EN
  logic [15:0] err_cnt;
  int          exp_err_cnt = 0;
`endif

  axi4_burst_slave_mem dut (
    .S_AXI_ACLK(tb_ACLK), .S_AXI_ARESETN(tb_ARESETN),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
    .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready), .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready), .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready), .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
`ifdef AXI_SLAVE_ERR_COUNT_EN
    , .S_AXI_ERR_CNT(err_cnt)
`endif
  );

  always #5 tb_ACLK = ~tb_ACLK;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] wbuf  [256];
  logic [3:0]  sbuf  [256];
  logic [31:0] rbuf  [256];
  logic [1:0]  rrbuf [256];
  logic        rlbuf [256];
  logic [31:0] vec16 [16];

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [1:0]  resp;
    logic [31:0] exp [8];
  } rd_vec_t;

  rd_vec_t tv [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int k, input logic [31:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] b, input logic [1:0] r,
                         input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2 = 32'h0, input logic [31:0] e3 = 32'h0,
                         input logic [31:0] e4 = 32'h0, input logic [31:0] e5 = 32'h0,
                         input logic [31:0] e6 = 32'h0, input logic [31:0] e7 = 32'h0);
    tv[k].addr = a; tv[k].len = l; tv[k].size = s; tv[k].burst = b; tv[k].resp = r;
    tv[k].exp[0] = e0; tv[k].exp[1] = e1; tv[k].exp[2] = e2; tv[k].exp[3] = e3;
    tv[k].exp[4] = e4; tv[k].exp[5] = e5; tv[k].exp[6] = e6; tv[k].exp[7] = e7;
  endtask

  // Drives AW then nbeats W beats (WLAST on the last one sent), then collects B.
  task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                          output logic [1:0] resp, output logic [ID_W-1:0] resp_id);
    int t;
    @(negedge tb_ACLK);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin @(negedge tb_ACLK); t++; end
    check("aw_handshake", 32'(awready), 32'd1);
    @(negedge tb_ACLK);
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == nbeats - 1); wvalid = 1'b1;
      t = 0;
      while (!wready && t < 50) begin @(negedge tb_ACLK); t++; end
      if (!wready) check("w_handshake", 32'(wready), 32'd1);
      @(negedge tb_ACLK);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    t = 0;
    while (!bvalid && t < 50) begin @(negedge tb_ACLK); t++; end
    check("b_valid", 32'(bvalid), 32'd1);
    resp = bresp; resp_id = bid;
    @(negedge tb_ACLK);
    bready = 1'b0;
  endtask

  // Issues AR and accepts beats with RREADY following rpat (bit k%4); checks stall stability.
  task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [3:0] rpat,
                         output int nacc);
    int t;
    int k;
    logic held;
    logic [31:0] hd;
    logic hl;
    logic [1:0] hr;
    @(negedge tb_ACLK);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin @(negedge tb_ACLK); t++; end
    check("ar_handshake", 32'(arready), 32'd1);
    @(negedge tb_ACLK);
    arvalid = 1'b0;
    nacc = 0; k = 0; held = 1'b0; hd = '0; hl = 1'b0; hr = '0; t = 0;
    while (nacc <= int'(len) && t < 2000) begin
      rready = rpat[2'(k)];
      k++;
      if (rvalid) begin
        if (held) begin
          check("r_stall_data", rdata, hd);
          check("r_stall_last", 32'(rlast), 32'(hl));
          check("r_stall_resp", 32'(rresp), 32'(hr));
        end
        if (rready) begin
          rbuf[nacc] = rdata; rrbuf[nacc] = rresp; rlbuf[nacc] = rlast;
          if (rid !== id) check("r_id", 32'(rid), 32'(id));
          nacc++;
          held = 1'b0;
        end else begin
          held = 1'b1; hd = rdata; hl = rlast; hr = rresp;
        end
      end
      @(negedge tb_ACLK);
      t++;
    end
    rready = 1'b0;
    check("r_valid_after_last", 32'(rvalid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] resp;
    logic [ID_W-1:0] rsp_id;
    int n;
    int t;

    tb_ARESETN = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;

    repeat (3) @(negedge tb_ACLK);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready",  32'(wready),  32'd0);
    check("rst_bvalid",  32'(bvalid),  32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_rlast",   32'(rlast),   32'd0);
    check("rst_rdata",   rdata,        32'd0);
    check("rst_bresp",   32'(bresp),   32'd0);
    check("rst_rresp",   32'(rresp),   32'd0);
`ifdef AXI_SLAVE_ERR_COUNT_EN
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    tb_ARESETN = 1'b1;
    @(negedge tb_ACLK);
    check("idle_awready", 32'(awready), 32'd1);
    check("idle_arready", 32'(arready), 32'd1);

    // 16-beat INCR write, 16-beat WRAP read from 0 returns it in order
    vec16 = '{32'hFFFFFFFF, 32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF,
              32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F,
              32'hF0F0F0F0, 32'h55555555, 32'hAAAAAAAA, 32'h13579BDF,
              32'h2468ACE0, 32'h80000001, 32'h7FFFFFFE, 32'h00ABCDEF};
    for (int i = 0; i < 16; i++) begin wbuf[i] = vec16[i]; sbuf[i] = 4'hF; end
    do_write(1'b1, 32'h0, 8'd15, 3'b010, 2'b01, 16, resp, rsp_id);
    check("wr16_bresp", 32'(resp), 32'd0);
    check("wr16_bid", 32'(rsp_id), 32'd1);
    do_read(1'b1, 32'h0, 8'd15, 3'b010, 2'b10, 4'hF, n);
    check("rd16_beats", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("rd16_data[%0d]", i), rbuf[i], vec16[i]);
      check($sformatf("rd16_resp[%0d]", i), 32'(rrbuf[i]), 32'd0);
      check($sformatf("rd16_last[%0d]", i), 32'(rlbuf[i]), 32'(i == 15));
    end

    // Word 63 then wrap to word 0; words 0..3 then overwritten with A0..A3
    wbuf[0] = 32'h5A5A5A5A; wbuf[1] = 32'hDEADBEEF; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
    do_write(1'b0, 32'hFC, 8'd1, 3'b010, 2'b01, 2, resp, rsp_id);
    check("wr_end_bresp", 32'(resp), 32'd0);
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + 32'(i); sbuf[i] = 4'hF; end
    do_write(1'b0, 32'h0, 8'd3, 3'b010, 2'b01, 4, resp, rsp_id);
    check("wr_a_bresp", 32'(resp), 32'd0);
    check("wr_a_bid", 32'(rsp_id), 32'd0);

    set_vec(0,  32'h08,  8'd3, 3'b010, 2'b10, 2'b00, 32'hA2, 32'hA3, 32'hA0, 32'hA1);
    set_vec(1,  32'h04,  8'd2, 3'b010, 2'b01, 2'b00, 32'hA1, 32'hA2, 32'hA3);
    set_vec(2,  32'h0C,  8'd2, 3'b010, 2'b00, 2'b00, 32'hA3, 32'hA3, 32'hA3);
    set_vec(3,  32'h04,  8'd1, 3'b010, 2'b10, 2'b00, 32'hA1, 32'hA0);
    set_vec(4,  32'h00,  8'd3, 3'b001, 2'b01, 2'b10, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    set_vec(5,  32'h00,  8'd1, 3'b010, 2'b11, 2'b10, 32'hA0, 32'hA1);
    set_vec(6,  32'h00,  8'd2, 3'b010, 2'b10, 2'b10, 32'hA0, 32'hA1, 32'hA2);
    set_vec(7,  32'h02,  8'd1, 3'b010, 2'b10, 2'b10, 32'hA0, 32'hA1);
    set_vec(8,  32'h100, 8'd1, 3'b010, 2'b01, 2'b00, 32'hA0, 32'hA1);
    set_vec(9,  32'hFC,  8'd1, 3'b010, 2'b01, 2'b00, 32'h5A5A5A5A, 32'hA0);
    set_vec(10, 32'h18,  8'd7, 3'b010, 2'b10, 2'b00, 32'h9ABCDEF0, 32'h0F0F0F0F,
            32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hCAFEF00D, 32'h12345678);

    for (int k = 0; k < 11; k++) begin
      do_read(1'b0, tv[k].addr, tv[k].len, tv[k].size, tv[k].burst, 4'hF, n);
      check($sformatf("vec%0d_beats", k), 32'(n), 32'(int'(tv[k].len) + 1));
      for (int i = 0; i <= int'(tv[k].len); i++) begin
        check($sformatf("vec%0d_data[%0d]", k, i), rbuf[i], tv[k].exp[i]);
        check($sformatf("vec%0d_resp[%0d]", k, i), 32'(rrbuf[i]), 32'(tv[k].resp));
        check($sformatf("vec%0d_last[%0d]", k, i), 32'(rlbuf[i]), 32'(i == int'(tv[k].len)));
      end
`ifdef AXI_SLAVE_ERR_COUNT_EN
      if (tv[k].resp == 2'b10) exp_err_cnt++;
`endif
    end

    // Byte strobes merge into the existing word
    wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
    do_write(1'b0, 32'h10, 8'd0, 3'b010, 2'b01, 1, resp, rsp_id);
    wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0101;
    do_write(1'b0, 32'h10, 8'd0, 3'b010, 2'b01, 1, resp, rsp_id);
    check("strb_bresp", 32'(resp), 32'd0);
    do_read(1'b0, 32'h10, 8'd0, 3'b010, 2'b01, 4'hF, n);
    check("strb_data", rbuf[0], 32'h11BB33DD);
    check("strb_last", 32'(rlbuf[0]), 32'd1);

    // RREADY 1,0,0,1 back-pressure on a 4-beat INCR read
    do_read(1'b1, 32'h0, 8'd3, 3'b010, 2'b01, 4'b1001, n);
    check("stall_beats", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall_data[%0d]", i), rbuf[i], 32'hA0 + 32'(i));
      check($sformatf("stall_last[%0d]", i), 32'(rlbuf[i]), 32'(i == 3));
    end

    // Write error cases
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hE0 + 32'(i); sbuf[i] = 4'hF; end
    do_write(1'b0, 32'h80, 8'd2, 3'b010, 2'b10, 3, resp, rsp_id);
    check("wrap_len2_bresp", 32'(resp), 32'd2);
    do_write(1'b1, 32'h90, 8'd2, 3'b010, 2'b01, 2, resp, rsp_id);
    check("early_wlast_bresp", 32'(resp), 32'd2);
    check("early_wlast_bid", 32'(rsp_id), 32'd1);
    wbuf[0] = 32'h1; wbuf[1] = 32'h2; wbuf[2] = 32'h3;
    do_write(1'b0, 32'h30, 8'd1, 3'b010, 2'b01, 3, resp, rsp_id);
    check("late_wlast_bresp", 32'(resp), 32'd2);
    do_read(1'b0, 32'h30, 8'd2, 3'b010, 2'b01, 4'hF, n);
    check("late_wlast_w12", rbuf[0], 32'h1);
    check("late_wlast_w13", rbuf[1], 32'h2);
    check("late_wlast_w14_kept", rbuf[2], 32'h7FFFFFFE);
`ifdef AXI_SLAVE_ERR_COUNT_EN
    exp_err_cnt += 3;
    check("err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
`endif

    // Reset while beat 5 of a 16-beat write is presented
    for (int i = 0; i < 16; i++) begin wbuf[i] = 32'hC0 + 32'(i); sbuf[i] = 4'hF; end
    @(negedge tb_ACLK);
    awid = 1'b0; awaddr = 32'h40; awlen = 8'd15; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin @(negedge tb_ACLK); t++; end
    check("mid_aw_handshake", 32'(awready), 32'd1);
    @(negedge tb_ACLK);
    awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wdata = wbuf[i]; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      t = 0;
      while (!wready && t < 50) begin @(negedge tb_ACLK); t++; end
      @(negedge tb_ACLK);
    end
    wdata = wbuf[4];
    check("mid_wready_before", 32'(wready), 32'd1);
    #2 tb_ARESETN = 1'b0;
    #1;
    check("mid_rst_awready", 32'(awready), 32'd0);
    check("mid_rst_wready",  32'(wready),  32'd0);
    check("mid_rst_bvalid",  32'(bvalid),  32'd0);
    check("mid_rst_arready", 32'(arready), 32'd0);
    @(negedge tb_ACLK);
    wvalid = 1'b0;
    tb_ARESETN = 1'b1;
    @(negedge tb_ACLK);
    check("post_rst_awready", 32'(awready), 32'd1);
    check("post_rst_arready", 32'(arready), 32'd1);
`ifdef AXI_SLAVE_ERR_COUNT_EN
    check("post_rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    wbuf[0] = 32'h600DF00D; sbuf[0] = 4'hF;
    do_write(1'b1, 32'hF8, 8'd0, 3'b010, 2'b01, 1, resp, rsp_id);
    check("post_rst_bresp", 32'(resp), 32'd0);
    do_read(1'b0, 32'hF8, 8'd0, 3'b010, 2'b01, 4'hF, n);
    check("post_rst_data", rbuf[0], 32'h600DF00D);
    do_read(1'b0, 32'h40, 8'd3, 3'b010, 2'b01, 4'hF, n);
    for (int i = 0; i < 4; i++) check($sformatf("partial_kept[%0d]", i), rbuf[i], 32'hC0 + 32'(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
